// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch-to-dispatch instruction buffer.
// Holds the fetch packet layout, default sizes and the debug view.
package inst_buffer_pkg;

   localparam int NUM_WAYS        = 2;
   localparam int IB_DEPTH        = 16;
   localparam int IB_DEPTH_BITS   = $clog2(IB_DEPTH);
   localparam int NUM_SCALAR_BITS = $clog2(NUM_WAYS + 1);

   typedef struct packed {
      logic       taken;
      logic [1:0] ctr;
   } BP_PACKET;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] PC;
      logic [31:0] NPC;
      BP_PACKET    bp_packet;
      logic [31:0] predicted_PC;
   } FETCH_PACKET;

   typedef struct packed {
      logic [IB_DEPTH_BITS-1:0] head;
      logic [IB_DEPTH_BITS-1:0] tail;
      logic [IB_DEPTH_BITS:0]   count;
   } IB_DEBUG;

endpackage

// File: rtl/inst_buffer.sv
// N-wide circular instruction buffer between fetch and dispatch.
// Ports: clock/reset (sync, active-high); fetch_valid/fetch_packets in,
//   ib_spots out (free slots, max N); num_dispatched in (head prefix
//   consumed); restore_valid in (full flush); inst_buffer_instructions_valid
//   and inst_buffer_packets out (head window, lanes past valid are zero).
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int  N     = NUM_WAYS,
   parameter int  IB_SZ = IB_DEPTH,
   localparam int IDX   = $clog2(IB_SZ),
   localparam int CW    = IDX + 1,
   localparam int SW    = $clog2(N + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [SW-1:0]         fetch_valid,
   input  FETCH_PACKET [N-1:0]   fetch_packets,
   output logic [SW-1:0]         ib_spots,
   input  logic [SW-1:0]         num_dispatched,
   input  logic                  restore_valid,
   output logic [SW-1:0]         inst_buffer_instructions_valid,
   output FETCH_PACKET [N-1:0]   inst_buffer_packets
`ifdef DEBUG
   ,
   output IB_DEBUG               ib_debug
`endif
);

   logic [IDX-1:0] head_q, head_d;
   logic [IDX-1:0] tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  free;
   logic [SW-1:0]  accepted;
   logic [SW-1:0]  deq;
   FETCH_PACKET    entries_q [IB_SZ];

   function automatic logic [SW-1:0] min_sw(
      input logic [SW-1:0] a,
      input logic [SW-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

   function automatic logic [SW-1:0] clamp_n(input logic [CW-1:0] v);
      return (v > CW'(N)) ? SW'(N) : SW'(v);
   endfunction

   // Spots use only the registered count: a same-cycle dequeue is not
   // credited, keeping dispatch off the fetch timing path.
   assign free                           = CW'(IB_SZ) - count_q;
   assign ib_spots                       = clamp_n(free);
   assign inst_buffer_instructions_valid = clamp_n(count_q);
   assign accepted = min_sw(fetch_valid, ib_spots);
   assign deq      = min_sw(num_dispatched, inst_buffer_instructions_valid);

   always_comb begin
      for (int i = 0; i < N; i++) begin
         inst_buffer_packets[i] = '0;
         if (SW'(i) < inst_buffer_instructions_valid)
            inst_buffer_packets[i] = entries_q[head_q + IDX'(i)];
      end
   end

   always_comb begin
      head_d  = head_q + IDX'(deq);
      tail_d  = tail_q + IDX'(accepted);
      count_d = count_q + CW'(accepted) - CW'(deq);
      if (restore_valid) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Contents are never cleared; the count masks stale entries.
   always_ff @(posedge clock) begin
      if (!reset && !restore_valid) begin
         for (int i = 0; i < N; i++) begin
            if (SW'(i) < accepted)
               entries_q[tail_q + IDX'(i)] <= fetch_packets[i];
         end
      end
   end

`ifdef DEBUG
   assign ib_debug = '{head: head_q, tail: tail_q, count: count_q};
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: a queue model predicts each cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int N  = 2;
   localparam int SZ = 16;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                restore_valid = 1'b0;
   logic [1:0]          fetch_valid = '0;
   logic [1:0]          num_dispatched = '0;
   logic [1:0]          ib_spots;
   logic [1:0]          valid_o;
   FETCH_PACKET [N-1:0] fetch_packets = '0;
   FETCH_PACKET [N-1:0] packets_o;

   inst_buffer #(.N(N), .IB_SZ(SZ)) dut (
      .clock                          (clock),
      .reset                          (reset),
      .fetch_valid                    (fetch_valid),
      .fetch_packets                  (fetch_packets),
      .ib_spots                       (ib_spots),
      .num_dispatched                 (num_dispatched),
      .restore_valid                  (restore_valid),
      .inst_buffer_instructions_valid (valid_o),
      .inst_buffer_packets            (packets_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          valid;
      int          spots;
      FETCH_PACKET pk [N];
   } exp_t;

   exp_t        exp_q [$];
   FETCH_PACKET model_q [$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] pc_ctr = '0;

   function automatic int mmin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic FETCH_PACKET make_pkt(input logic [31:0] pc);
      FETCH_PACKET p;
      p.inst         = $urandom;
      p.PC           = pc;
      p.NPC          = pc + 32'd4;
      p.bp_packet    = 3'($urandom);
      p.predicted_PC = $urandom;
      return p;
   endfunction

   // One clock of stimulus; the model then advances and its
   // prediction for the new state is queued for the monitor.
   task automatic step(input int fv, input int nd,
                       input bit rs, input bit rst);
      int   spots, acc, dq;
      exp_t e;
      spots = mmin(SZ - model_q.size(), N);
      acc   = mmin(fv, spots);
      dq    = mmin(nd, mmin(model_q.size(), N));
      reset          = rst;
      restore_valid  = rs;
      fetch_valid    = fv[1:0];
      num_dispatched = nd[1:0];
      for (int i = 0; i < N; i++)
         fetch_packets[i] = make_pkt(pc_ctr + 32'(4 * i));
      @(posedge clock);
      #1;
      if (rst || rs) begin
         model_q.delete();
      end else begin
         repeat (dq) void'(model_q.pop_front());
         for (int i = 0; i < acc; i++)
            model_q.push_back(fetch_packets[i]);
         pc_ctr = pc_ctr + 32'(4 * acc);
      end
      e.valid = mmin(model_q.size(), N);
      e.spots = mmin(SZ - model_q.size(), N);
      for (int i = 0; i < N; i++)
         e.pk[i] = (i < e.valid) ? model_q[i] : '0;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (valid_o !== 2'(e.valid)) begin
               errors++;
               $display("FAIL valid: got %0d want %0d at %0t",
                        valid_o, e.valid, $time);
            end
            checks++;
            if (ib_spots !== 2'(e.spots)) begin
               errors++;
               $display("FAIL spots: got %0d want %0d at %0t",
                        ib_spots, e.spots, $time);
            end
            for (int i = 0; i < N; i++) begin
               checks++;
               if (packets_o[i] !== e.pk[i]) begin
                  errors++;
                  $display("FAIL lane%0d: got %h want %h at %0t",
                           i, packets_o[i], e.pk[i], $time);
               end
            end
         end
      end
   end

   initial begin
      int nd;
      // reset, then idle
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);
      // fill to 16; the 9th push is dropped
      repeat (9) step(2, 0, 0, 0);
      // steady stream across wrap
      repeat (20) step(2, 2, 0, 0);
      // partial dispatch at count 5
      step(0, 0, 1, 0);
      step(2, 0, 0, 0);
      step(2, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      // restore at count 7 with push and dispatch
      step(2, 0, 0, 0);
      step(1, 0, 0, 0);
      step(2, 1, 1, 0);
      step(2, 0, 0, 0);
      step(0, 0, 0, 0);
      // reset while full
      repeat (8) step(2, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      // random traffic
      repeat (400) begin
         nd = $urandom_range(0, mmin(model_q.size(), N));
         step($urandom_range(0, 2), nd,
              $urandom_range(0, 99) < 3,
              $urandom_range(0, 199) < 1);
      end
      step(0, 0, 0, 0);
      @(negedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
